led_activity_ctrl: RTL and testbench

//  Drives the board's cog-activity LEDs from the raw cog_led vector of the core.
//  Per LED: makes short activity visible (hold), then fades out, with PWM brightness.
//  A global max_level input caps brightness, replacing the fixed 1/8 dim tap.

---
 rtl/led_ctrl_pkg.sv | 25 ++
 rtl/led_channel.sv | 103 ++++++++++
 rtl/led_activity_ctrl.sv | 53 +++++
 tb/tb_led_activity_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types and width helpers for the cog-activity LED controller.
package led_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, LIT, FADE} led_state_t;

  localparam int DEF_NUM_LEDS        = 8;
  localparam int DEF_PWM_BITS        = 3;
  localparam int DEF_PRESC_BITS      = 14;
  localparam int DEF_HOLD_TICKS      = 1000;
  localparam int DEF_FADE_STEP_TICKS = 250;

  localparam int DEF_LEVEL_W = DEF_PWM_BITS + 1;
  localparam int DEF_HOLD_W  = $clog2(DEF_HOLD_TICKS + 1);
  localparam int DEF_FADE_W  = $clog2(DEF_FADE_STEP_TICKS + 1);

  // Level needs one extra bit so that 2**pwm_bits (always on) is representable.
  function automatic int level_width(input int pwm_bits);
    return pwm_bits + 1;
  endfunction

  function automatic int count_width(input int ticks);
    return $clog2(ticks + 1);
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: input synchroniser, hold/fade state machine and PWM compare.
module led_channel
  import led_ctrl_pkg::*;
#(
  parameter int PWM_BITS        = DEF_PWM_BITS,
  parameter int HOLD_TICKS      = DEF_HOLD_TICKS,
  parameter int FADE_STEP_TICKS = DEF_FADE_STEP_TICKS
) (
  input  logic                clock_160,
  input  logic                nres,
  input  logic                act,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic [PWM_BITS:0]   max_level,
  output logic                led,
  output logic                busy
);

  localparam int LEVEL_W = level_width(PWM_BITS);
  localparam int HOLD_W  = count_width(HOLD_TICKS);
  localparam int FADE_W  = count_width(FADE_STEP_TICKS);

  localparam logic [LEVEL_W-1:0] FULL      = {1'b1, {PWM_BITS{1'b0}}};
  localparam logic [LEVEL_W-1:0] LEVEL_ONE = {{PWM_BITS{1'b0}}, 1'b1};
  localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(HOLD_TICKS);
  localparam logic [FADE_W-1:0]  FADE_INIT = FADE_W'(FADE_STEP_TICKS);
  localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
  localparam logic [FADE_W-1:0]  FADE_ONE  = FADE_W'(1);

  logic [1:0]         sync;
  logic               act_s;
  led_state_t         state;
  logic [LEVEL_W-1:0] level;
  logic [HOLD_W-1:0]  hold;
  logic [FADE_W-1:0]  fade;
  logic [LEVEL_W-1:0] eff;

  always_ff @(posedge clock_160 or negedge nres) begin
    if (!nres) sync <= '0;
    else       sync <= {sync[0], act};
  end

  assign act_s = sync[1];

  // The global cap only limits what reaches the pin; the channel level is untouched.
  assign eff = (level < max_level) ? level : max_level;

  always_ff @(posedge clock_160 or negedge nres) begin
    if (!nres) begin
      state <= IDLE;
      level <= '0;
      hold  <= '0;
      fade  <= '0;
      led   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      led  <= ({1'b0, pwm_cnt} < eff);
      busy <= (state != IDLE);
      case (state)
        IDLE: begin
          if (act_s) begin
            state <= LIT;
            level <= FULL;
            hold  <= HOLD_INIT;
          end
        end
        LIT: begin
          if (act_s) begin
            hold <= HOLD_INIT;
          end else if (tick) begin
            if (hold == HOLD_ONE) begin
              state <= FADE;
              fade  <= FADE_INIT;
            end else begin
              hold <= hold - 1'b1;
            end
          end
        end
        FADE: begin
          if (act_s) begin
            state <= LIT;
            level <= FULL;
            hold  <= HOLD_INIT;
          end else if (tick) begin
            if (fade == FADE_ONE) begin
              fade <= FADE_INIT;
              if (level == LEVEL_ONE) begin
                state <= IDLE;
                level <= '0;
              end else begin
                level <= level - 1'b1;
              end
            end else begin
              fade <= fade - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/led_activity_ctrl.sv
// Cog-activity LED driver: shared tick prescaler and PWM counter feeding
// one hold/fade channel per LED.
module led_activity_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int NUM_LEDS        = DEF_NUM_LEDS,
  parameter int PWM_BITS        = DEF_PWM_BITS,
  parameter int PRESC_BITS      = DEF_PRESC_BITS,
  parameter int HOLD_TICKS      = DEF_HOLD_TICKS,
  parameter int FADE_STEP_TICKS = DEF_FADE_STEP_TICKS
) (
  input  logic                clock_160,
  input  logic                nres,
  input  logic [NUM_LEDS-1:0] act_in,
  input  logic [PWM_BITS:0]   max_level,
  output logic [NUM_LEDS-1:0] led_out,
  output logic [NUM_LEDS-1:0] busy
);

  logic [PRESC_BITS-1:0] presc;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic                  tick;

  always_ff @(posedge clock_160 or negedge nres) begin
    if (!nres) begin
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      presc   <= presc + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  assign tick = &presc;

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_channel #(
      .PWM_BITS       (PWM_BITS),
      .HOLD_TICKS     (HOLD_TICKS),
      .FADE_STEP_TICKS(FADE_STEP_TICKS)
    ) u_ch (
      .clock_160(clock_160),
      .nres     (nres),
      .act      (act_in[i]),
      .tick     (tick),
      .pwm_cnt  (pwm_cnt),
      .max_level(max_level),
      .led      (led_out[i]),
      .busy     (busy[i])
    );
  end

endmodule

// File: tb/tb_led_activity_ctrl.sv
// Directed self-checking bench for led_activity_ctrl with small tick/hold/fade values.
module tb_led_activity_ctrl;

  logic       clock_160 = 1'b0;
  logic       nres;
  logic [7:0] act_in;
  logic [3:0] max_level;
  logic [7:0] led_out;
  logic [7:0] busy;

  int tests = 0;
  int fails = 0;
  int cyc;

  led_activity_ctrl #(
    .NUM_LEDS       (8),
    .PWM_BITS       (3),
    .PRESC_BITS     (2),
    .HOLD_TICKS     (3),
    .FADE_STEP_TICKS(2)
  ) dut (
    .clock_160(clock_160),
    .nres     (nres),
    .act_in   (act_in),
    .max_level(max_level),
    .led_out  (led_out),
    .busy     (busy)
  );

  always #5 clock_160 = ~clock_160;

  // Edges since reset release; after edge k the prescaler is k%4 and pwm_cnt is k%8.
  always @(posedge clock_160 or negedge nres) begin
    if (!nres) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clock_160);
    #1;
  endtask

  task automatic apply_reset();
    nres   = 1'b0;
    act_in = '0;
    repeat (3) @(posedge clock_160);
    @(negedge clock_160);
    nres = 1'b1;
  endtask

  task automatic test_reset();
    int bad;
    bad       = 0;
    act_in    = '0;
    max_level = 4'd8;
    nres      = 1'b1;
    #2;
    nres = 1'b0;
    repeat (3) begin
      step();
      if (led_out !== 8'h00 || busy !== 8'h00) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("[TB] FAIL reset_hold: got %0d nonzero samples, expected 0", bad);
    end
    @(negedge clock_160);
    nres = 1'b1;
    bad  = 0;
    repeat (100) begin
      step();
      if (led_out !== 8'h00 || busy !== 8'h00) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("[TB] FAIL idle_after_reset: got %0d nonzero samples, expected 0", bad);
    end
  endtask

  task automatic test_fade_sequence();
    int full_ones, busy_bad, other_bad, tail_ones, e;
    int win[7];
    full_ones = 0; busy_bad = 0; other_bad = 0; tail_ones = 0;
    for (int j = 0; j < 7; j++) win[j] = 0;
    apply_reset();
    max_level = 4'd8;
    while (cyc < 96) begin
      act_in = (cyc == 7) ? 8'h01 : 8'h00;
      step();
      e = cyc - 8;
      if (e == 2) begin
        tests++;
        if (busy[0] !== 1'b0) begin
          fails++;
          $display("[TB] FAIL fade_latency_early: got busy0=%b, expected 0", busy[0]);
        end
      end
      if (e == 3) begin
        tests++;
        if (busy[0] !== 1'b1 || led_out[0] !== 1'b1) begin
          fails++;
          $display("[TB] FAIL fade_latency: got busy0=%b led0=%b, expected 1 1", busy[0], led_out[0]);
        end
      end
      if (e >= 3 && e <= 20 && led_out[0] === 1'b1) full_ones++;
      if (e >= 21 && e <= 76 && led_out[0] === 1'b1) win[(e - 21) / 8]++;
      if (e >= 3 && busy[0] !== (e <= 76)) busy_bad++;
      if (e >= 77 && led_out[0] !== 1'b0) tail_ones++;
      if (led_out[7:1] !== 7'h00 || busy[7:1] !== 7'h00) other_bad++;
    end
    tests++;
    if (full_ones !== 18) begin
      fails++;
      $display("[TB] FAIL fade_full: got %0d on-cycles, expected 18", full_ones);
    end
    for (int j = 0; j < 7; j++) begin
      tests++;
      if (win[j] !== 7 - j) begin
        fails++;
        $display("[TB] FAIL fade_duty_step%0d: got %0d/8, expected %0d/8", j, win[j], 7 - j);
      end
    end
    tests++;
    if (busy_bad !== 0 || tail_ones !== 0) begin
      fails++;
      $display("[TB] FAIL fade_busy_end: got %0d busy errors %0d late on-cycles, expected 0 0", busy_bad, tail_ones);
    end
    tests++;
    if (other_bad !== 0) begin
      fails++;
      $display("[TB] FAIL fade_other_bits: got %0d disturbed samples, expected 0", other_bad);
    end
  endtask

  task automatic test_max_level();
    int ones, bad;
    apply_reset();
    max_level = 4'd8;
    act_in    = 8'h08;
    while (cyc < 20) step();
    tests++;
    if (led_out[3] !== 1'b1 || busy[3] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL max8_on: got led3=%b busy3=%b, expected 1 1", led_out[3], busy[3]);
    end
    max_level = 4'd0;
    step();
    tests++;
    if (led_out[3] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL max_change_latency: got led3=%b, expected 0", led_out[3]);
    end
    ones = 0; bad = 0;
    repeat (8) begin
      step();
      if (led_out[3] === 1'b1) ones++;
      if (busy[3] !== 1'b1) bad++;
    end
    tests++;
    if (ones !== 0 || bad !== 0) begin
      fails++;
      $display("[TB] FAIL max0_off: got %0d on-cycles %0d idle, expected 0 0", ones, bad);
    end
    max_level = 4'd15;
    step();
    ones = 0;
    repeat (8) begin
      step();
      if (led_out[3] === 1'b1) ones++;
    end
    tests++;
    if (ones !== 8) begin
      fails++;
      $display("[TB] FAIL max15_saturate: got %0d/8, expected 8/8", ones);
    end
    max_level = 4'd3;
    step();
    ones = 0;
    repeat (8) begin
      step();
      if (led_out[3] === 1'b1) ones++;
    end
    tests++;
    if (ones !== 3) begin
      fails++;
      $display("[TB] FAIL max3_duty: got %0d/8, expected 3/8", ones);
    end
    act_in    = '0;
    max_level = 4'd8;
  endtask

  task automatic test_retrigger();
    int lvl5, full, lvl7, e;
    lvl5 = 0; full = 0; lvl7 = 0;
    apply_reset();
    max_level = 4'd8;
    while (cyc < 88) begin
      act_in = (cyc == 7 || cyc == 53) ? 8'h04 : 8'h00;
      step();
      e = cyc - 8;
      if (e >= 37 && e <= 44 && led_out[2] === 1'b1) lvl5++;
      if (e >= 49 && e <= 68 && led_out[2] === 1'b1) full++;
      if (e >= 69 && e <= 76 && led_out[2] === 1'b1) lvl7++;
    end
    tests++;
    if (lvl5 !== 5) begin
      fails++;
      $display("[TB] FAIL retrig_pre_level5: got %0d/8, expected 5/8", lvl5);
    end
    tests++;
    if (full !== 20) begin
      fails++;
      $display("[TB] FAIL retrig_full: got %0d on-cycles, expected 20", full);
    end
    tests++;
    if (lvl7 !== 7) begin
      fails++;
      $display("[TB] FAIL retrig_post_level7: got %0d/8, expected 7/8", lvl7);
    end
  endtask

  task automatic test_hold_active();
    int on_cnt, busy_cnt, lvl7;
    on_cnt = 0; busy_cnt = 0; lvl7 = 0;
    apply_reset();
    max_level = 4'd8;
    while (cyc < 140) begin
      act_in = (cyc >= 7 && cyc < 103) ? 8'h02 : 8'h00;
      step();
      if (cyc >= 11 && cyc <= 124) begin
        if (led_out[1] === 1'b1) on_cnt++;
        if (busy[1] === 1'b1) busy_cnt++;
      end
      if (cyc >= 125 && cyc <= 132 && led_out[1] === 1'b1) lvl7++;
    end
    tests++;
    if (on_cnt !== 114 || busy_cnt !== 114) begin
      fails++;
      $display("[TB] FAIL hold_active_on: got %0d on %0d busy, expected 114 114", on_cnt, busy_cnt);
    end
    tests++;
    if (lvl7 !== 7) begin
      fails++;
      $display("[TB] FAIL hold_release_fade: got %0d/8, expected 7/8", lvl7);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    max_level = 4'd8;
    while (cyc < 40) begin
      act_in = (cyc == 7) ? 8'hA5 : 8'h00;
      step();
      if (cyc == 10) begin
        tests++;
        if (busy !== 8'h00) begin
          fails++;
          $display("[TB] FAIL multi_early: got busy=%h, expected 00", busy);
        end
      end
      if (cyc == 11) begin
        tests++;
        if (busy !== 8'hA5 || led_out !== 8'hA5) begin
          fails++;
          $display("[TB] FAIL multi_start: got busy=%h led=%h, expected a5 a5", busy, led_out);
        end
      end
    end
    tests++;
    if (busy !== 8'hA5) begin
      fails++;
      $display("[TB] FAIL multi_midfade: got busy=%h, expected a5", busy);
    end
    #2;
    nres = 1'b0;
    #1;
    tests++;
    if (led_out !== 8'h00 || busy !== 8'h00) begin
      fails++;
      $display("[TB] FAIL async_clear: got led=%h busy=%h, expected 00 00", led_out, busy);
    end
    repeat (2) step();
    @(negedge clock_160);
    nres = 1'b1;
    repeat (10) step();
    tests++;
    if (led_out !== 8'h00 || busy !== 8'h00) begin
      fails++;
      $display("[TB] FAIL post_reset_idle: got led=%h busy=%h, expected 00 00", led_out, busy);
    end
  endtask

  initial begin
    nres      = 1'b1;
    act_in    = '0;
    max_level = 4'd8;
    test_reset();
    test_fade_sequence();
    test_max_level();
    test_retrigger();
    test_hold_active();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
